multicycle_controller: RTL and testbench

Control FSM that sequences the RV32I datapath (pc, instruction memory, register_file, ALU) over multiple cycles per instruction: fetch, decode, execute, memory, writeback. It drives the instruction- and data-memory request/ready handshakes, register-file write enable, mux selects, ALU op and PC update. It halts on illegal opcodes or memory timeouts, and counts retired instructions.

---
 rtl/cpu_pkg.sv | 77 +++++++
 rtl/alu_decoder.sv | 36 +++
 rtl/multicycle_controller.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the RV32I multicycle controller: FSM states, opcodes,
// and the select/op encodings that the datapath decodes.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JAL    = 2'd2,
    PC_JALR   = 2'd3
  } pc_src_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wdata_sel_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_t;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic imm_sel_t imm_sel_for(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_LUI, OP_AUIPC: return IMM_U;
      OP_JAL:           return IMM_J;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-op decode from opcode, funct3 and funct7[5].
module alu_decoder
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output alu_op_t    alu_op
);

  logic is_r;
  logic is_arith;

  assign is_r     = (opcode == OP_R);
  assign is_arith = is_r || (opcode == OP_IMM);

  always_comb begin
    alu_op = ALU_ADD;
    if (is_arith) begin
      case (funct3)
        // I-type has no subtract: bit 30 is part of the immediate there
        3'b000: if (is_r && funct7_b5) alu_op = ALU_SUB; else alu_op = ALU_ADD;
        3'b001: alu_op = ALU_SLL;
        3'b010: alu_op = ALU_SLT;
        3'b011: alu_op = ALU_SLTU;
        3'b100: alu_op = ALU_XOR;
        3'b101: if (funct7_b5) alu_op = ALU_SRA; else alu_op = ALU_SRL;
        3'b110: alu_op = ALU_OR;
        3'b111: alu_op = ALU_AND;
      endcase
    end else if (opcode == OP_LUI) begin
      alu_op = ALU_PASS_B;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: fetch/decode/execute/mem/writeback sequencing,
// memory handshakes with wait timeout, halt on illegal opcode, retire counter.
module multicycle_controller
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             rf_write_enable,
  output logic [1:0]       rf_wdata_sel,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic [2:0]       imm_sel,
  output logic [3:0]       alu_op,
  output logic             halted,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired_count
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  state_t            state;
  state_t            state_nxt;
  logic              active;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;
  logic              stall;
  logic              wait_expired;
  logic              illegal_set;
  logic              timeout_set;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  alu_op_t           dec_alu_op;
  logic              unused_instr_bits;

  assign opcode            = instruction[6:0];
  assign rd                = instruction[11:7];
  assign unused_instr_bits = ^{instruction[31], instruction[29:15]};

  alu_decoder u_alu_decoder (
    .opcode    (opcode),
    .funct3    (instruction[14:12]),
    .funct7_b5 (instruction[30]),
    .alu_op    (dec_alu_op)
  );

  // Requests stay low while reset is held and until the first edge after release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_FETCH;
      active        <= 1'b0;
      wait_cnt      <= '0;
      illegal       <= 1'b0;
      timeout       <= 1'b0;
      retired_count <= '0;
    end else begin
      active   <= 1'b1;
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (illegal_set) illegal <= 1'b1;
      if (timeout_set) timeout <= 1'b1;
      if (pc_write)    retired_count <= retired_count + CNT_W'(1);
    end
  end

  assign stall = active && (((state == S_FETCH) && !imem_ready) ||
                            ((state == S_MEM)   && !dmem_ready));
  assign wait_expired = stall && (wait_cnt == WAIT_W'(MEM_WAIT_MAX - 1));

  always_comb begin
    state_nxt   = state;
    illegal_set = 1'b0;
    timeout_set = 1'b0;
    if (active) begin
      case (state)
        S_FETCH: begin
          if (wait_expired) begin
            state_nxt   = S_HALT;
            timeout_set = 1'b1;
          end else if (imem_ready) begin
            state_nxt = S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_legal_opcode(opcode)) begin
            state_nxt = S_EXECUTE;
          end else begin
            state_nxt   = S_HALT;
            illegal_set = 1'b1;
          end
        end
        S_EXECUTE: begin
          if ((opcode == OP_LOAD) || (opcode == OP_STORE)) state_nxt = S_MEM;
          else if (opcode == OP_BRANCH)                    state_nxt = S_FETCH;
          else                                             state_nxt = S_WRITEBACK;
        end
        S_MEM: begin
          if (wait_expired) begin
            state_nxt   = S_HALT;
            timeout_set = 1'b1;
          end else if (dmem_ready) begin
            state_nxt = (opcode == OP_LOAD) ? S_WRITEBACK : S_FETCH;
          end
        end
        S_WRITEBACK: state_nxt = S_FETCH;
        S_HALT:      state_nxt = S_HALT;
        default:     state_nxt = S_HALT;
      endcase
    end
  end

  // Wait counter only runs across consecutive stall cycles in the same state
  assign wait_cnt_nxt = (stall && (state_nxt == state)) ? wait_cnt + WAIT_W'(1) : '0;

  always_comb begin
    imem_req        = 1'b0;
    dmem_req        = 1'b0;
    dmem_we         = 1'b0;
    ir_write        = 1'b0;
    pc_write        = 1'b0;
    pc_src          = PC_PLUS4;
    rf_write_enable = 1'b0;
    rf_wdata_sel    = WB_ALU;
    alu_src_a       = 1'b0;
    alu_src_b       = 1'b0;
    imm_sel         = IMM_I;
    alu_op          = ALU_ADD;
    if (active) begin
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
        end
        S_EXECUTE: begin
          alu_op    = dec_alu_op;
          alu_src_a = (opcode == OP_AUIPC);
          alu_src_b = !((opcode == OP_R) || (opcode == OP_BRANCH));
          imm_sel   = imm_sel_for(opcode);
          if (opcode == OP_BRANCH) begin
            pc_write = 1'b1;
            pc_src   = branch_taken ? PC_BRANCH : PC_PLUS4;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (opcode == OP_STORE);
          if ((opcode == OP_STORE) && dmem_ready) pc_write = 1'b1;
        end
        S_WRITEBACK: begin
          rf_write_enable = (rd != 5'd0);
          pc_write        = 1'b1;
          if (opcode == OP_LOAD) begin
            rf_wdata_sel = WB_MEM;
          end else if (opcode == OP_JAL) begin
            rf_wdata_sel = WB_PC4;
            pc_src       = PC_JAL;
          end else if (opcode == OP_JALR) begin
            rf_wdata_sel = WB_PC4;
            pc_src       = PC_JALR;
          end
        end
        default: ;
      endcase
    end
  end

  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a driver issues instructions and
// memory latencies, a monitor compares each retire/halt against a latency model.
module tb_multicycle_controller;

  localparam int WAIT_MAX  = 15;
  localparam int TB_CNT_W  = 4;
  localparam int CNT_MOD   = 1 << TB_CNT_W;
  localparam int LIMIT     = 80;

  localparam logic [6:0] T_R      = 7'b0110011;
  localparam logic [6:0] T_IMM    = 7'b0010011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;

  logic                clk = 1'b0;
  logic                reset;
  logic [31:0]         instruction;
  logic                imem_req, imem_ready;
  logic                dmem_req, dmem_we, dmem_ready;
  logic                branch_taken;
  logic                ir_write, pc_write;
  logic [1:0]          pc_src;
  logic                rf_write_enable;
  logic [1:0]          rf_wdata_sel;
  logic                alu_src_a, alu_src_b;
  logic [2:0]          imm_sel;
  logic [3:0]          alu_op;
  logic                halted, illegal, timeout;
  logic [TB_CNT_W-1:0] retired_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int halt; int illegal; int timeout; int cycles;
    int pc_src; int rf_we; int wsel; int alu_op;
    int src_a; int src_b; int imm; int dmem_cycles; int we;
  } exp_t;

  exp_t exp_q[$];
  logic [6:0] legal_ops [9] = '{T_R, T_IMM, T_LOAD, T_STORE, T_BRANCH, T_JAL, T_JALR, T_LUI, T_AUIPC};

  multicycle_controller #(.MEM_WAIT_MAX(WAIT_MAX), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .branch_taken(branch_taken), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .rf_write_enable(rf_write_enable), .rf_wdata_sel(rf_wdata_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_sel(imm_sel), .alu_op(alu_op),
    .halted(halted), .illegal(illegal), .timeout(timeout), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // ALU op numbering: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASS_B10
  function automatic int ref_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    int by_f3 [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    if (op == T_LUI) return 10;
    if (op != T_R && op != T_IMM) return 0;
    if (op == T_R && f3 == 3'd0 && f7) return 1;
    if (f3 == 3'd5 && f7) return 7;
    return by_f3[f3];
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input bit tk, input int il, input int dl);
    exp_t e;
    logic [6:0] op;
    int fetch;
    int writes;
    e = '{default: 0};
    op = ins[6:0];
    writes = (ins[11:7] != 5'd0) ? 1 : 0;
    if (il >= WAIT_MAX) begin
      e.halt = 1; e.timeout = 1; e.cycles = WAIT_MAX + 1;
      return e;
    end
    fetch = il + 1;
    if (!(op inside {T_R, T_IMM, T_LOAD, T_STORE, T_BRANCH, T_JAL, T_JALR, T_LUI, T_AUIPC})) begin
      e.halt = 1; e.illegal = 1; e.cycles = fetch + 2;
      return e;
    end
    e.alu_op = ref_alu(op, ins[14:12], ins[30]);
    e.src_a  = (op == T_AUIPC) ? 1 : 0;
    e.src_b  = (op == T_R || op == T_BRANCH) ? 0 : 1;
    case (op)
      T_STORE:         e.imm = 1;
      T_BRANCH:        e.imm = 2;
      T_LUI, T_AUIPC:  e.imm = 3;
      T_JAL:           e.imm = 4;
      default:         e.imm = 0;
    endcase
    if (op == T_BRANCH) begin
      e.cycles = fetch + 2;
      e.pc_src = tk ? 1 : 0;
    end else if (op == T_LOAD || op == T_STORE) begin
      if (dl >= WAIT_MAX) begin
        e.halt = 1; e.timeout = 1; e.cycles = fetch + 2 + WAIT_MAX + 1;
        return e;
      end
      e.dmem_cycles = dl + 1;
      e.we = (op == T_STORE) ? 1 : 0;
      if (op == T_STORE) e.cycles = fetch + 3 + dl;
      else begin
        e.cycles = fetch + 4 + dl; e.rf_we = writes; e.wsel = 1;
      end
    end else begin
      e.cycles = fetch + 3;
      e.rf_we  = writes;
      e.wsel   = (op == T_JAL || op == T_JALR) ? 2 : 0;
      e.pc_src = (op == T_JAL) ? 2 : (op == T_JALR) ? 3 : 0;
    end
    return e;
  endfunction

  task automatic run_instr(input logic [31:0] ins, input bit tk, input int il, input int dl);
    int ic, dc, budget;
    bit done;
    exp_q.push_back(model(ins, tk, il, dl));
    instruction  = ins;
    branch_taken = tk;
    ic = 0; dc = 0; budget = 0; done = 0;
    while (!done) begin
      if (imem_req) begin imem_ready = (ic == il); ic++; end
      else imem_ready = 1'($urandom_range(0, 1));
      if (dmem_req) begin dmem_ready = (dc == dl); dc++; end
      else dmem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (pc_write || halted) done = 1;
      budget++;
      if (!done && budget >= LIMIT) begin
        checks++; errors++;
        $display("FAIL instr_budget: no retire or halt after %0d cycles, expected within %0d", budget, LIMIT);
        done = 1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      imem_ready = 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_strobes", 32'({imem_req, dmem_req, dmem_we, ir_write, pc_write, rf_write_enable}), 32'd0);
    chk("rst_flags", 32'({halted, illegal, timeout}), 32'd0);
    chk("rst_selects", 32'({pc_src, rf_wdata_sel, alu_src_a, alu_src_b, imm_sel, alu_op}), 32'd0);
    chk("rst_retired", 32'(retired_count), 32'd0);
    exp_q.delete();
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("fetch_after_release", 32'(imem_req), 32'd1);
  endtask

  // Monitor: pops one expectation per retire (pc_write) or halt
  initial begin : monitor
    int cyc, e_at, ir_cnt, rfwe_cnt, dreq_cnt, we_seen, retired_model;
    bit halt_seen;
    exp_t e;
    cyc = 0; e_at = -1; ir_cnt = 0; rfwe_cnt = 0; dreq_cnt = 0; we_seen = 0;
    retired_model = 0; halt_seen = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc = 0; e_at = -1; ir_cnt = 0; rfwe_cnt = 0; dreq_cnt = 0; we_seen = 0;
        retired_model = 0; halt_seen = 0;
      end else if (halt_seen) begin
        chk("halt_quiet", 32'({imem_req, dmem_req, ir_write, pc_write, rf_write_enable}), 32'd0);
        chk("halt_retired", 32'(retired_count), 32'(retired_model % CNT_MOD));
      end else begin
        cyc++;
        if (ir_write) begin ir_cnt++; e_at = cyc + 2; end
        if (rf_write_enable) rfwe_cnt++;
        if (dmem_req) begin dreq_cnt++; if (dmem_we) we_seen = 1; end
        if (halted) begin
          halt_seen = 1;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL halt_unexpected: halted=1, expected no pending instruction to halt");
          end else begin
            e = exp_q.pop_front();
            chk("halt_expected", 32'd1, 32'(e.halt));
            chk("halt_flags", 32'({illegal, timeout}), 32'({e.illegal[0], e.timeout[0]}));
            chk("halt_cycles", 32'(cyc), 32'(e.cycles));
            chk("halt_retired", 32'(retired_count), 32'(retired_model % CNT_MOD));
          end
        end else begin
          if (cyc == e_at && exp_q.size() > 0) begin
            e = exp_q[0];
            chk("exec_alu_op", 32'(alu_op), 32'(e.alu_op));
            chk("exec_srcs", 32'({alu_src_a, alu_src_b}), 32'({e.src_a[0], e.src_b[0]}));
            chk("exec_imm_sel", 32'(imm_sel), 32'(e.imm));
          end
          if (pc_write) begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL retire_unexpected: pc_write=1, expected no pending instruction");
            end else begin
              e = exp_q.pop_front();
              chk("retire_not_halt", 32'd0, 32'(e.halt));
              chk("retire_cycles", 32'(cyc), 32'(e.cycles));
              chk("retire_pc_src", 32'(pc_src), 32'(e.pc_src));
              chk("retire_rf_we", 32'(rfwe_cnt), 32'(e.rf_we));
              chk("retire_wsel", 32'(rf_wdata_sel), 32'(e.wsel));
              chk("retire_dmem_cycles", 32'(dreq_cnt), 32'(e.dmem_cycles));
              chk("retire_dmem_we", 32'(we_seen), 32'(e.we));
              chk("retire_ir_write", 32'(ir_cnt), 32'd1);
              chk("retired_count", 32'(retired_count), 32'(retired_model % CNT_MOD));
            end
            retired_model++;
            cyc = 0; e_at = -1; ir_cnt = 0; rfwe_cnt = 0; dreq_cnt = 0; we_seen = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    reset = 1'b1;
    instruction = 32'h0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    branch_taken = 1'b0;
    @(posedge clk); #1;
    do_reset();

    run_instr(32'h005303b3, 1'b0, 0, 0);   // add x7,x6,x5
    run_instr(32'h40530333, 1'b0, 0, 0);   // sub x6,x6,x5
    run_instr(32'h00530033, 1'b0, 0, 0);   // add x0,x6,x5
    run_instr(32'h00012083, 1'b0, 0, 3);   // lw x1,0(x2), 3 late
    run_instr(32'h00112223, 1'b0, 1, 1);   // sw x1,4(x2)
    run_instr(32'h00000063, 1'b1, 0, 0);   // beq taken
    run_instr(32'h00000063, 1'b0, 0, 0);   // beq not taken
    run_instr(32'h40315093, 1'b0, 0, 0);   // srai
    run_instr(32'h40010093, 1'b0, 0, 0);   // addi with bit30 set
    run_instr(32'h123452b7, 1'b0, 0, 0);   // lui
    run_instr(32'h00000297, 1'b0, 2, 0);   // auipc
    run_instr(32'h000000ef, 1'b0, 0, 0);   // jal
    run_instr(32'h000100e7, 1'b0, 0, 0);   // jalr
    run_instr(32'h005303b3, 1'b0, WAIT_MAX - 1, 0);
    run_instr(32'h00012083, 1'b0, 0, WAIT_MAX - 1);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] ins;
      ins = $urandom();
      ins[6:0] = legal_ops[$urandom_range(0, 8)];
      run_instr(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    run_instr(32'h00000000, 1'b0, 0, 0);   // illegal
    idle(5);
    do_reset();

    run_instr(32'h005303b3, 1'b0, WAIT_MAX, 0);   // fetch timeout
    idle(4);
    do_reset();

    run_instr(32'h00012083, 1'b0, 0, WAIT_MAX);   // data timeout
    idle(4);
    do_reset();

    for (int n = 0; n < 3; n++) begin
      logic [31:0] ins;
      ins = $urandom();
      while (ins[6:0] inside {T_R, T_IMM, T_LOAD, T_STORE, T_BRANCH, T_JAL, T_JALR, T_LUI, T_AUIPC})
        ins[6:0] = 7'($urandom());
      run_instr(32'h005303b3, 1'b0, 1, 0);
      run_instr(ins, 1'b0, $urandom_range(0, 2), 0);
      idle(3);
      do_reset();
    end

    begin : mid_mem_reset
      int seen;
      int guard;
      seen = 0;
      guard = 0;
      exp_q.push_back(model(32'h00012083, 1'b0, 0, 100));
      instruction = 32'h00012083;
      while (seen < 3 && guard < 30) begin
        imem_ready = imem_req;
        dmem_ready = 1'b0;
        @(negedge clk);
        if (dmem_req) seen++;
        guard++;
        @(posedge clk); #1;
      end
      chk("mid_mem_req_before_reset", 32'(dmem_req), 32'd1);
      do_reset();
    end
    run_instr(32'h005303b3, 1'b0, 0, 0);
    run_instr(32'h00112223, 1'b0, 0, 0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
